geo_clip_sequencer: RTL and testbench

//  Sequences the geometry clip stage: accepts one transformed triangle per handshake from the vertex shader,

---
 rtl/geo_clip_sequencer.sv | 134 +++++++++++++
 tb/tb_geo_clip_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/geo_clip_sequencer.sv
// geo_clip_sequencer: sequences one triangle at a time through the clipper and on to the rasteriser
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   tri_valid_i/tri_ready_o/tri_data_i vertex shader triangle handshake (12 components, v0.x at LSBs)
//   clip_start_o/clip_tri_o            one-cycle launch pulse and captured triangle for the clipper
//   clip_done_i/clip_num_tri_i         clipper completion pulse and result count (0..2, 3 is illegal)
//   clip_tri0_i/clip_tri1_i            clipper result triangles, sampled with clip_done_i
//   rast_valid_o/rast_ready_i          rasteriser handshake, valid never drops before acceptance
//   rast_tri_o/rast_last_o             triangle to rasteriser, last triangle from the current input
//   busy_o                             any state other than IDLE
//   cull_cnt_o                         fully culled triangles, saturating
//   out_cnt_o                          triangles delivered to the rasteriser, wrapping
//   err_o                              one-cycle pulse on illegal result count or watchdog expiry
//
// Configuration: define GEO_SEQ_TIMEOUT_EN to enable a watchdog that abandons the triangle after
// TIMEOUT_CYCLES cycles in WAIT without clip_done_i.
module geo_clip_sequencer #(
    parameter int VERTEX_WIDTH   = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tri_valid_i,
    output logic                       tri_ready_o,
    input  logic [12*VERTEX_WIDTH-1:0] tri_data_i,
    output logic                       clip_start_o,
    output logic [12*VERTEX_WIDTH-1:0] clip_tri_o,
    input  logic                       clip_done_i,
    input  logic [1:0]                 clip_num_tri_i,
    input  logic [12*VERTEX_WIDTH-1:0] clip_tri0_i,
    input  logic [12*VERTEX_WIDTH-1:0] clip_tri1_i,
    output logic                       rast_valid_o,
    input  logic                       rast_ready_i,
    output logic [12*VERTEX_WIDTH-1:0] rast_tri_o,
    output logic                       rast_last_o,
    output logic                       busy_o,
    output logic [CNT_WIDTH-1:0]       cull_cnt_o,
    output logic [CNT_WIDTH-1:0]       out_cnt_o,
    output logic                       err_o
);
    localparam int TW = 12 * VERTEX_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EMIT0, S_EMIT1} state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        clip_tri_q, tri0_q, tri1_q;
    logic                 single_q;
    logic [CNT_WIDTH-1:0] cull_q, out_q;
    logic                 done_w, hs_w, timeout_w;

    // A done pulse only counts in WAIT, so one arriving during LAUNCH (or late, in IDLE) is ignored.
    assign done_w = (state_q == S_WAIT) && clip_done_i;
    assign hs_w   = ((state_q == S_EMIT0) || (state_q == S_EMIT1)) && rast_ready_i;

`ifdef GEO_SEQ_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] wait_cnt_q;

    // Held at zero outside WAIT, so it counts from zero on every WAIT entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + TCW'(1) : '0;
    end

    assign timeout_w = (state_q == S_WAIT) && !clip_done_i && (wait_cnt_q == TO_LAST);
`else
    // No watchdog: WAIT lasts until the clipper answers; the term is constant false for legal parameters.
    assign timeout_w = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = tri_valid_i ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   state_d = done_w ? ((clip_num_tri_i == 2'd1 || clip_num_tri_i == 2'd2) ? S_EMIT0 : S_IDLE)
                                       : (timeout_w ? S_IDLE : S_WAIT);
            S_EMIT0:  state_d = rast_ready_i ? (single_q ? S_IDLE : S_EMIT1) : S_EMIT0;
            S_EMIT1:  state_d = rast_ready_i ? S_IDLE : S_EMIT1;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tri_ready_o  = rst_ni && (state_q == S_IDLE);
        clip_start_o = state_q == S_LAUNCH;
        busy_o       = state_q != S_IDLE;
        rast_valid_o = (state_q == S_EMIT0) || (state_q == S_EMIT1);
        rast_last_o  = (state_q == S_EMIT1) || ((state_q == S_EMIT0) && single_q);
        rast_tri_o   = (state_q == S_EMIT1) ? tri1_q : tri0_q;
        err_o        = (done_w && clip_num_tri_i == 2'd3) || timeout_w;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clip_tri_q <= '0;
            tri0_q     <= '0;
            tri1_q     <= '0;
            single_q   <= 1'b0;
            cull_q     <= '0;
            out_q      <= '0;
        end else begin
            if ((state_q == S_IDLE) && tri_valid_i)
                clip_tri_q <= tri_data_i;
            if (done_w) begin
                tri0_q   <= clip_tri0_i;
                tri1_q   <= clip_tri1_i;
                single_q <= clip_num_tri_i == 2'd1;
            end
            if (done_w && clip_num_tri_i == 2'd0 && cull_q != '1)
                cull_q <= cull_q + CNT_WIDTH'(1);
            if (hs_w)
                out_q <= out_q + CNT_WIDTH'(1);
        end
    end

    assign clip_tri_o = clip_tri_q;
    assign cull_cnt_o = cull_q;
    assign out_cnt_o  = out_q;

endmodule

// File: tb/tb_geo_clip_sequencer.sv
// tb_geo_clip_sequencer: directed table, corner sequences and randomized transaction-level checks
module tb_geo_clip_sequencer;
    localparam int VW = 32;
    localparam int W  = 12 * VW;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0, rst_ni = 1'b0;
    logic          tri_valid_i = 1'b0, clip_done_i = 1'b0, rast_ready_i = 1'b0;
    logic [1:0]    clip_num_tri_i = 2'd0;
    logic [W-1:0]  tri_data_i = '0, clip_tri0_i = '0, clip_tri1_i = '0;
    logic          tri_ready_o, clip_start_o, rast_valid_o, rast_last_o, busy_o, err_o;
    logic [W-1:0]  clip_tri_o, rast_tri_o;
    logic [CW-1:0] cull_cnt_o, out_cnt_o;

    geo_clip_sequencer #(.VERTEX_WIDTH(VW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o), .tri_data_i(tri_data_i),
        .clip_start_o(clip_start_o), .clip_tri_o(clip_tri_o),
        .clip_done_i(clip_done_i), .clip_num_tri_i(clip_num_tri_i),
        .clip_tri0_i(clip_tri0_i), .clip_tri1_i(clip_tri1_i),
        .rast_valid_o(rast_valid_o), .rast_ready_i(rast_ready_i),
        .rast_tri_o(rast_tri_o), .rast_last_o(rast_last_o),
        .busy_o(busy_o), .cull_cnt_o(cull_cnt_o), .out_cnt_o(out_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;

    typedef struct {
        logic [1:0] num;
        int         lat;
        int         stall;
        bit         err;
        int         cull;
        int         outc;
    } vec_t;

    typedef struct {
        logic [W-1:0] t;
        logic         l;
    } beat_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; tri_valid_i = 1'b0; clip_done_i = 1'b0; rast_ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One full transaction: accept, launch, clipper answers after lat WAIT cycles, then beats with stalls.
    task automatic run_tri(input logic [1:0] num, input int lat, input int stall, input bit exp_err);
        logic [W-1:0] d, t0, t1;
        int beats;
        beats = (num == 2'd1) ? 1 : (num == 2'd2) ? 2 : 0;
        d = rnd(); t0 = rnd(); t1 = rnd();
        @(negedge clk_i);
        tri_valid_i = 1'b1; tri_data_i = d;
        #1 chk("ready_idle", tri_ready_o, 1);
        @(negedge clk_i);
        tri_valid_i = 1'b0; tri_data_i = rnd();
        #1 chk("start", clip_start_o, 1);
        chk("clip_tri", clip_tri_o, d);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk_i);
            clip_done_i = (i == lat); clip_num_tri_i = num; clip_tri0_i = t0; clip_tri1_i = t1;
            #1 chk("start_once", clip_start_o, 0);
            chk("busy_wait", busy_o, 1);
            chk("ready_busy", tri_ready_o, 0);
            chk("err", err_o, exp_err && (i == lat));
            chk("clip_tri_hold", clip_tri_o, d);
        end
        @(negedge clk_i);
        clip_done_i = 1'b0; clip_tri0_i = rnd(); clip_tri1_i = rnd();
        for (int b = 0; b < beats; b++) begin
            for (int s = 0; s <= stall; s++) begin
                rast_ready_i = (s == stall);
                #1 chk("rast_valid", rast_valid_o, 1);
                chk("rast_tri", rast_tri_o, (b == 0) ? t0 : t1);
                chk("rast_last", rast_last_o, b == beats - 1);
                chk("err_emit", err_o, 0);
                @(negedge clk_i);
            end
        end
        rast_ready_i = 1'b0;
        #1 chk("ready_after", tri_ready_o, 1);
        chk("valid_after", rast_valid_o, 0);
        chk("busy_after", busy_o, 0);
    endtask

    vec_t  tbl[7];
    beat_t q[$];
    beat_t bt;
    logic [W-1:0] d, acc;
    int cd, culls, nbeats, errs;
    bit armed, inflight, launch_exp;

    initial begin
        tbl[0] = '{2'd1, 4, 0, 1'b0, 0, 1};
        tbl[1] = '{2'd2, 1, 5, 1'b0, 0, 3};
        tbl[2] = '{2'd0, 2, 0, 1'b0, 1, 3};
        tbl[3] = '{2'd0, 1, 0, 1'b0, 2, 3};
        tbl[4] = '{2'd0, 3, 0, 1'b0, 3, 3};
        tbl[5] = '{2'd3, 2, 0, 1'b1, 3, 3};
        tbl[6] = '{2'd2, 1, 2, 1'b0, 3, 5};

        repeat (2) @(negedge clk_i);
        #1 chk("rst_ready", tri_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", rast_valid_o, 0);
        chk("rst_start", clip_start_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_last", rast_last_o, 0);
        chk("rst_cull", cull_cnt_o, 0);
        chk("rst_out", out_cnt_o, 0);
        chk("rst_clip_tri", clip_tri_o, 0);
        chk("rst_rast_tri", rast_tri_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 chk("rel_ready", tri_ready_o, 1);

        for (int r = 0; r < 7; r++) begin
            run_tri(tbl[r].num, tbl[r].lat, tbl[r].stall, tbl[r].err);
            chk("tbl_cull", cull_cnt_o, tbl[r].cull);
            chk("tbl_out", out_cnt_o, tbl[r].outc);
        end

        // Reset while a split result is stalled in EMIT0.
        @(negedge clk_i);
        tri_valid_i = 1'b1; tri_data_i = rnd();
        @(negedge clk_i);
        tri_valid_i = 1'b0;
        @(negedge clk_i);
        clip_done_i = 1'b1; clip_num_tri_i = 2'd2; clip_tri0_i = rnd();
        @(negedge clk_i);
        clip_done_i = 1'b0; rast_ready_i = 1'b0;
        #1 chk("mid_valid", rast_valid_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1 chk("mid_rst_valid", rast_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_cull", cull_cnt_o, 0);
        chk("mid_rst_out", out_cnt_o, 0);
        chk("mid_rst_ready", tri_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 chk("mid_rel_ready", tri_ready_o, 1);

        // Cull counter saturates at all-ones.
        for (int i = 0; i < CMAX + 5; i++) run_tri(2'd0, 1, 0, 1'b0);
        chk("cull_sat", cull_cnt_o, CMAX);
        chk("cull_sat_out", out_cnt_o, 0);

        // Randomized traffic against a transaction-level model.
        pulse_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            clip_done_i = 1'b0;
            if (armed) begin
                cd--;
                if (cd == 0) begin
                    clip_done_i = 1'b1;
                    armed = 1'b0;
                end
            end
            clip_num_tri_i = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            clip_tri0_i = rnd(); clip_tri1_i = rnd();
            rast_ready_i = ($urandom_range(0, 2) != 0);
            tri_valid_i = 1'($urandom_range(0, 1));
            tri_data_i = rnd();
            #1 chk("r_ready", tri_ready_o, !inflight);
            chk("r_start", clip_start_o, launch_exp);
            chk("r_err", err_o, clip_done_i && clip_num_tri_i == 2'd3);
            chk("r_cull", cull_cnt_o, (culls > CMAX) ? CMAX : culls);
            chk("r_out", out_cnt_o, nbeats % (CMAX + 1));
            chk("r_valid", rast_valid_o, q.size() > 0);
            if (rast_valid_o && rast_ready_i && q.size() > 0) begin
                bt = q.pop_front();
                chk("r_tri", rast_tri_o, bt.t);
                chk("r_last", rast_last_o, bt.l);
                if (bt.l) inflight = 1'b0;
                nbeats++;
            end
            if (clip_start_o) begin
                chk("r_clip_tri", clip_tri_o, acc);
                armed = 1'b1;
                cd = $urandom_range(1, 5);
            end
            launch_exp = tri_valid_i && tri_ready_o;
            if (launch_exp) begin
                acc = tri_data_i;
                inflight = 1'b1;
            end
            if (clip_done_i) begin
                if (clip_num_tri_i == 2'd0) culls++;
                if (clip_num_tri_i == 2'd0 || clip_num_tri_i == 2'd3) inflight = 1'b0;
                if (clip_num_tri_i == 2'd1) q.push_back('{clip_tri0_i, 1'b1});
                if (clip_num_tri_i == 2'd2) begin
                    q.push_back('{clip_tri0_i, 1'b0});
                    q.push_back('{clip_tri1_i, 1'b1});
                end
            end
        end

        // Clipper never answers.
        pulse_reset();
        @(negedge clk_i);
        tri_valid_i = 1'b1; d = rnd(); tri_data_i = d;
        @(negedge clk_i);
        tri_valid_i = 1'b0; clip_done_i = 1'b0; rast_ready_i = 1'b1;
`ifdef GEO_SEQ_TIMEOUT_EN
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk_i);
            #1 chk("to_err", err_o, i == 64);
            chk("to_busy", busy_o, 1);
        end
        @(negedge clk_i);
        #1 chk("to_idle", busy_o, 0);
        chk("to_ready", tri_ready_o, 1);
        clip_done_i = 1'b1; clip_num_tri_i = 2'd1;
        @(negedge clk_i);
        clip_done_i = 1'b0;
        #1 chk("late_valid", rast_valid_o, 0);
        chk("late_busy", busy_o, 0);
        chk("late_out", out_cnt_o, 0);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            #1 if (err_o) errs++;
        end
        chk("no_to_busy", busy_o, 1);
        chk("no_to_err", errs, 0);
        chk("no_to_clip_tri", clip_tri_o, d);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
